// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N producer channels, the arbiter and one consumer.
// The slave modport is the arbiter's view; the master modport is the
// environment that drives the channels and consumes the output word.
interface rr_arb_mux_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int CW = $clog2(N);

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_ch;
  logic           out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ch,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ch,
    output out_ready
  );
endinterface

// File: rtl/rr_arb_mux.sv
// N-channel arbiter feeding a single registered output word.
// mode 0 grants the lowest valid index; mode 1 scans round-robin from r_ptr.
// r_ptr always advances past the last granted channel, in both modes, so a
// switch to round-robin continues fairly from where traffic last came from.
module rr_arb_mux #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  rr_arb_mux_if.slave     bus
);
  localparam int CW = $clog2(N);

  logic [CW-1:0] r_ptr;
  logic          r_outValid;
  logic [W-1:0]  r_outData;
  logic [CW-1:0] r_outCh;

  logic          w_loadEn;
  logic          w_anyValid;
  logic [CW-1:0] w_grantIdx;
  logic [N-1:0]  w_grant;
  logic [CW-1:0] w_ptrNext;

  // Output slot can take a new word when empty or being drained this cycle
  assign w_loadEn   = !r_outValid || bus.out_ready;
  assign w_anyValid = |bus.in_valid;

  // Pick the granted channel index; loops run backwards so the first hit in scan order wins
  always_comb begin
    int j;
    j          = 0;
    w_grantIdx = '0;
    if (!mode) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (bus.in_valid[i]) begin
          w_grantIdx = CW'(i);
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        j = int'(r_ptr) + k;
        if (j >= N) begin
          j = j - N;
        end
        if (bus.in_valid[j]) begin
          w_grantIdx = CW'(j);
        end
      end
    end
  end

  // One-hot grant, pointer successor with wrap, and gated per-channel accept
  always_comb begin
    w_grant   = w_anyValid ? ({{(N-1){1'b0}}, 1'b1} << w_grantIdx) : '0;
    w_ptrNext = (w_grantIdx == CW'(N - 1)) ? '0 : w_grantIdx + 1'b1;
    bus.in_ready = (rst_n && w_loadEn) ? w_grant : '0;
  end

  // Output register and round-robin pointer; hold everything under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outCh    <= '0;
      r_ptr      <= '0;
    end else if (w_loadEn) begin
      if (w_anyValid) begin
        r_outValid <= 1'b1;
        r_outData  <= bus.in_data[int'(w_grantIdx)*W +: W];
        r_outCh    <= w_grantIdx;
        r_ptr      <= w_ptrNext;
      end else begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_outValid;
  assign bus.out_data  = r_outData;
  assign bus.out_ch    = r_outCh;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed self-checking bench for rr_arb_mux (W=8, N=4).
// Inputs change 1 ns after a rising edge; registered outputs are checked
// 1 ns after the edge, combinational in_ready before the following edge.
module tb_rr_arb_mux;
  localparam int W = 8;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  logic mode;
  int   assertCount;
  int   failCount;

  rr_arb_mux_if #(.W(W), .N(N)) bus ();

  rr_arb_mux #(.W(W), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .bus   (bus.slave)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive the channel inputs and output-side ready
  task automatic applyStimulus(input logic m, input logic [N-1:0] v,
                               input logic [N*W-1:0] d, input logic rdy);
    mode          = m;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = rdy;
  endtask

  // Advance to 1 ns past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [N*W-1:0] DATA_A = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  localparam logic [N*W-1:0] DATA_B = {8'h5D, 8'h5C, 8'h5B, 8'h5A};

  logic [7:0] expData [4];

  // Main directed sequence
  initial begin
    assertCount = 0;
    failCount   = 0;
    expData[0] = 8'hA0; expData[1] = 8'hA1; expData[2] = 8'hA2; expData[3] = 8'hA3;

    // Reset with requests already pending: nothing accepted, outputs cleared
    rst_n = 1'b0;
    applyStimulus(1'b1, 4'b1111, DATA_A, 1'b1);
    #2;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data",  32'(bus.out_data),  32'd0);
    checkOutput("rst_out_ch",    32'(bus.out_ch),    32'd0);
    checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("rr_first_in_ready", 32'(bus.in_ready), 32'b0001);

    // Round-robin fairness: all four requesting, sequence 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("rr_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("rr_out_ch",    32'(bus.out_ch),    32'(k % 4));
      checkOutput("rr_out_data",  32'(bus.out_data),  32'(expData[k % 4]));
    end
    checkOutput("rr_in_ready_after", 32'(bus.in_ready), 32'b0010);

    // Fixed priority on 1010: channel 1 every cycle
    applyStimulus(1'b0, 4'b1010, DATA_A, 1'b1);
    #1;
    checkOutput("fp_in_ready", 32'(bus.in_ready), 32'b0010);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("fp_out_ch",   32'(bus.out_ch),   32'd1);
      checkOutput("fp_out_data", 32'(bus.out_data), 32'hA1);
      checkOutput("fp_in_ready_hold", 32'(bus.in_ready), 32'b0010);
    end

    // Load channel 2 (pointer becomes 3), then stall for three cycles with churning inputs
    applyStimulus(1'b0, 4'b0100, DATA_A, 1'b1);
    tick();
    checkOutput("bp_load_ch", 32'(bus.out_ch), 32'd2);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(k[0], 4'(k + 1) | 4'b1000, DATA_B ^ 32'(k), 1'b0);
      #1;
      checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_out_ch",    32'(bus.out_ch),    32'd2);
      checkOutput("bp_out_data",  32'(bus.out_data),  32'hA2);
    end

    // Release with round-robin from pointer 3 on 0101: wrap to 0, then skip 1 to reach 2
    applyStimulus(1'b1, 4'b0101, DATA_A, 1'b1);
    #1;
    checkOutput("wrap_in_ready", 32'(bus.in_ready), 32'b0001);
    tick();
    checkOutput("wrap_out_ch",   32'(bus.out_ch),   32'd0);
    checkOutput("wrap_out_data", 32'(bus.out_data), 32'hA0);
    checkOutput("skip_in_ready", 32'(bus.in_ready), 32'b0100);
    tick();
    checkOutput("skip_out_ch",   32'(bus.out_ch),   32'd2);
    checkOutput("skip_out_data", 32'(bus.out_data), 32'hA2);

    // Idle drain: word taken, nothing new, valid drops and data is kept
    applyStimulus(1'b1, 4'b0000, DATA_A, 1'b1);
    #1;
    checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    checkOutput("idle_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("idle_out_data",  32'(bus.out_data),  32'hA2);
    checkOutput("idle_out_ch",    32'(bus.out_ch),    32'd2);

    // Pointer is 3: request on channel 1 only, load it, then stall
    applyStimulus(1'b1, 4'b0010, DATA_A, 1'b1);
    tick();
    checkOutput("hold_out_ch", 32'(bus.out_ch), 32'd1);
    applyStimulus(1'b1, 4'b0010, DATA_A, 1'b0);
    tick();
    checkOutput("hold_out_valid", 32'(bus.out_valid), 32'd1);

    // Reset pulse between edges clears the held word at once
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_rst_out_data",  32'(bus.out_data),  32'd0);
    checkOutput("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
    applyStimulus(1'b1, 4'b1000, DATA_A, 1'b1);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'b1000);
    tick();
    checkOutput("post_rst_out_ch",   32'(bus.out_ch),   32'd3);
    checkOutput("post_rst_out_data", 32'(bus.out_data), 32'hA3);
    applyStimulus(1'b1, 4'b1111, DATA_A, 1'b1);
    #1;
    checkOutput("post_rst_ptr_wrap", 32'(bus.in_ready), 32'b0001);
    tick();
    checkOutput("post_rst_next_ch", 32'(bus.out_ch), 32'd0);

    // Pointer is 1: mode flip changes the grant combinationally
    applyStimulus(1'b1, 4'b1001, DATA_A, 1'b1);
    #1;
    checkOutput("mode_rr_in_ready", 32'(bus.in_ready), 32'b1000);
    mode = 1'b0;
    #1;
    checkOutput("mode_fp_in_ready", 32'(bus.in_ready), 32'b0001);
    tick();
    checkOutput("mode_fp_out_ch", 32'(bus.out_ch), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected sequence completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
